// File: rtl/alu_test_console.sv
// Bring-up console: debounced keys sequence A/B/opcode entry from one switch bank into an ALU,
// capture its result and flags, and drive paged active-low seven-segment digits.
module alu_test_console #(
  parameter int WIDTH     = 32,
  parameter int DIGITS    = 8,
  parameter int DB_CYCLES = 500000
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [17:0]         sw,
  input  logic [3:0]          key_n,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [3:0]          alu_op,
  input  logic [WIDTH-1:0]    alu_out,
  input  logic [2:0]          alu_flags,
  output logic [2:0]          flags,
  output logic [2:0]          state,
  output logic [DIGITS*7-1:0] hex
);

  localparam int NIB   = WIDTH / 4;
  localparam int PAGES = (NIB + DIGITS - 1) / DIGITS;
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CW    = $clog2(DB_CYCLES + 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  logic unused_inputs;
  assign unused_inputs = ^{sw[17], key_n[3]};

  // Keys are kept active-high internally: 1 = pressed.
  logic [2:0]    press_raw;
  logic [2:0]    sync1_q, sync2_q, db_q, evt_q;
  logic [CW-1:0] cnt_q [3];

  assign press_raw = ~key_n[2:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      evt_q   <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q <= press_raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        evt_q[k] <= 1'b0;
        if (sync2_q[k] != db_q[k]) begin
          if (cnt_q[k] == CW'(DB_CYCLES - 1)) begin
            db_q[k]  <= sync2_q[k];
            cnt_q[k] <= '0;
            evt_q[k] <= sync2_q[k];
          end else begin
            cnt_q[k] <= cnt_q[k] + CW'(1);
          end
        end else begin
          cnt_q[k] <= '0;
        end
      end
    end
  end

  logic enter_ev, clear_ev, page_ev;
  assign enter_ev = evt_q[0];
  assign clear_ev = evt_q[1];
  assign page_ev  = evt_q[2];

  logic [WIDTH-1:0] ext;
  assign ext = WIDTH'({{WIDTH{sw[16]}}, sw[15:0]});

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       flags_q, flags_d;
  logic [PW-1:0]    page_q, page_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    page_d   = page_q;
    if (page_ev) page_d = (page_q == PW'(PAGES - 1)) ? '0 : page_q + PW'(1);
    if (clear_ev) begin
      state_d  = LOAD_A;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      result_d = '0;
      flags_d  = '0;
      page_d   = '0;
    end else begin
      case (state_q)
        LOAD_A:  if (enter_ev) begin a_d = ext; state_d = LOAD_B; end
        LOAD_B:  if (enter_ev) begin b_d = ext; state_d = LOAD_OP; end
        LOAD_OP: if (enter_ev) begin op_d = sw[3:0]; state_d = EXEC; end
        // ALU is combinational; operands have been stable for a full cycle here.
        EXEC: begin
          result_d = alu_out;
          flags_d  = alu_flags;
          state_d  = SHOW;
        end
        SHOW:    if (enter_ev) state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      page_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      page_q   <= page_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h27;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [WIDTH-1:0]    disp_val;
  logic [DIGITS*7-1:0] hex_d, hex_q;
  int                  idx;

  always_comb begin
    disp_val = result_q;
    case (state_q)
      LOAD_A, LOAD_B: disp_val = ext;
      LOAD_OP:        disp_val = WIDTH'(sw[3:0]);
      default:        disp_val = result_q;
    endcase
  end

  // Nibbles past the top of the datapath on the last page are blanked.
  always_comb begin
    hex_d = '1;
    idx   = 0;
    for (int i = 0; i < DIGITS; i++) begin
      idx = int'(page_q) * DIGITS + i;
      if (idx < NIB) hex_d[i*7 +: 7] = seg7(4'(disp_val >> (4 * idx)));
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) hex_q <= '1;
    else       hex_q <= hex_d;
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign flags  = flags_q;
  assign state  = state_q;
  assign hex    = hex_q;

endmodule

// File: tb/tb_alu_test_console.sv
// Bench for alu_test_console: two instances (8 and 3 digits) share the board inputs, each with a stub ALU.
module tb_alu_test_console;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [17:0] sw;
  logic [3:0]  key_n;

  logic [31:0] a8, b8, out8, a3, b3, out3;
  logic [3:0]  op8, op3;
  logic [2:0]  fin8, fin3, flags8, flags3, state8, state3;
  logic [55:0] hex8;
  logic [20:0] hex3;

  int n_pass = 0;
  int n_chk  = 0;
  logic [31:0] exp_res_q[$];
  logic [2:0]  exp_flg_q[$];

  always #5 clk = ~clk;

  // Stub ALU: 2 = ADD with signed overflow, A = {a[15:0], b[15:0]}, others XOR.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    logic ov;
    r  = a ^ b;
    ov = 1'b0;
    if (op == 4'h2) begin
      r  = a + b;
      ov = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == 4'hA) begin
      r = {a[15:0], b[15:0]};
    end
    return {r[31], ov, (r == 32'd0), r};
  endfunction

  assign {fin8, out8} = alu_model(a8, b8, op8);
  assign {fin3, out3} = alu_model(a3, b3, op3);

  alu_test_console #(.WIDTH(32), .DIGITS(8), .DB_CYCLES(DB)) dut8 (
    .CLK(clk), .nRST(nrst), .sw(sw), .key_n(key_n),
    .alu_a(a8), .alu_b(b8), .alu_op(op8), .alu_out(out8), .alu_flags(fin8),
    .flags(flags8), .state(state8), .hex(hex8)
  );

  alu_test_console #(.WIDTH(32), .DIGITS(3), .DB_CYCLES(DB)) dut3 (
    .CLK(clk), .nRST(nrst), .sw(sw), .key_n(key_n),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_out(out3), .alu_flags(fin3),
    .flags(flags3), .state(state3), .hex(hex3)
  );

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [55:0] exp_hex8(input logic [31:0] v);
    logic [55:0] h;
    for (int i = 0; i < 8; i++) h[i*7 +: 7] = seg7(v[i*4 +: 4]);
    return h;
  endfunction

  function automatic logic [20:0] exp_hex3(input logic [31:0] v, input int page);
    logic [20:0] h;
    int n;
    for (int i = 0; i < 3; i++) begin
      n = page * 3 + i;
      h[i*7 +: 7] = (n >= 8) ? 7'h7F : seg7(v[n*4 +: 4]);
    end
    return h;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    key_n[k] = 1'b0;
    step(DB + 6);
    key_n[k] = 1'b1;
    step(DB + 6);
  endtask

  task automatic wait_show();
    for (int i = 0; i < 50 && state8 !== 3'd4; i++) step(1);
  endtask

  task automatic test_reset();
    nrst = 1'b0; key_n = 4'hF; sw = '0;
    step(2);
    n_chk++; if (state8 !== 3'd0) $display("FAIL reset_state got %0d want 0", state8); else n_pass++;
    n_chk++; if ({a8, b8, op8, flags8} !== '0) $display("FAIL reset_regs got %h %h %h %b want 0", a8, b8, op8, flags8); else n_pass++;
    n_chk++; if (hex8 !== {8{7'h7F}}) $display("FAIL reset_hex8 got %h want %h", hex8, {8{7'h7F}}); else n_pass++;
    n_chk++; if (hex3 !== {3{7'h7F}}) $display("FAIL reset_hex3 got %h want %h", hex3, {3{7'h7F}}); else n_pass++;
    nrst = 1'b1;
    step(2);
  endtask

  task automatic test_add();
    logic [31:0] r; logic [2:0] f;
    sw = {2'b00, 16'h0005}; press(0);
    n_chk++; if (a8 !== 32'h5 || state8 !== 3'd1) $display("FAIL add_load_a got a=%h st=%0d want 5/1", a8, state8); else n_pass++;
    sw = {2'b00, 16'h0003}; press(0);
    n_chk++; if (b8 !== 32'h3 || state8 !== 3'd2) $display("FAIL add_load_b got b=%h st=%0d want 3/2", b8, state8); else n_pass++;
    sw = {2'b00, 16'h0002};
    exp_res_q.push_back(32'd8); exp_flg_q.push_back(3'b000);
    press(0);
    n_chk++; if (op8 !== 4'h2) $display("FAIL add_load_op got %h want 2", op8); else n_pass++;
    wait_show();
    n_chk++; if (state8 !== 3'd4 || exp_res_q.size() == 0) $display("FAIL add_show st=%0d q=%0d want 4/nonempty", state8, exp_res_q.size()); else n_pass++;
    r = exp_res_q.pop_front(); f = exp_flg_q.pop_front();
    n_chk++; if (hex8 !== exp_hex8(r)) $display("FAIL add_hex8 got %h want %h", hex8, exp_hex8(r)); else n_pass++;
    n_chk++; if (hex3 !== exp_hex3(r, 0)) $display("FAIL add_hex3 got %h want %h", hex3, exp_hex3(r, 0)); else n_pass++;
    n_chk++; if (flags8 !== f) $display("FAIL add_flags got %b want %b", flags8, f); else n_pass++;
  endtask

  task automatic test_sign_fill();
    logic [31:0] r; logic [2:0] f;
    press(0);
    n_chk++; if (state8 !== 3'd0 || a8 !== 32'h5) $display("FAIL show_to_load_a st=%0d a=%h want 0/5", state8, a8); else n_pass++;
    sw = {2'b01, 16'hFFFF}; press(0);
    n_chk++; if (a8 !== 32'hFFFF_FFFF) $display("FAIL fill_a got %h want ffffffff", a8); else n_pass++;
    sw = {2'b00, 16'h0001}; press(0);
    n_chk++; if (b8 !== 32'h1) $display("FAIL fill_b got %h want 1", b8); else n_pass++;
    sw = {2'b00, 16'h0002};
    exp_res_q.push_back(32'd0); exp_flg_q.push_back(3'b001);
    press(0);
    wait_show();
    n_chk++; if (state8 !== 3'd4 || exp_res_q.size() == 0) $display("FAIL fill_show st=%0d q=%0d want 4/nonempty", state8, exp_res_q.size()); else n_pass++;
    r = exp_res_q.pop_front(); f = exp_flg_q.pop_front();
    n_chk++; if (hex8 !== exp_hex8(r)) $display("FAIL fill_hex8 got %h want %h", hex8, exp_hex8(r)); else n_pass++;
    n_chk++; if (flags8 !== f) $display("FAIL fill_flags got %b want %b", flags8, f); else n_pass++;
  endtask

  task automatic test_debounce();
    int lat;
    press(0);
    sw = {2'b00, 16'h1234};
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      step(2);
    end
    n_chk++; if (state8 !== 3'd0) $display("FAIL bounce_ignored st=%0d want 0", state8); else n_pass++;
    key_n[0] = 1'b0;
    lat = 0;
    while (state8 === 3'd0 && lat < 20) begin step(1); lat++; end
    n_chk++; if (lat < 2 + DB || lat > 3 + DB) $display("FAIL db_latency got %0d want %0d..%0d", lat, 2 + DB, 3 + DB); else n_pass++;
    step(15);
    n_chk++; if (state8 !== 3'd1 || a8 !== 32'h1234) $display("FAIL db_single st=%0d a=%h want 1/1234", state8, a8); else n_pass++;
    key_n[0] = 1'b1;
    step(DB + 6);
  endtask

  task automatic test_clear();
    sw = {2'b00, 16'h00AB}; press(0);
    n_chk++; if (state8 !== 3'd2 || b8 !== 32'hAB) $display("FAIL clr_pre st=%0d b=%h want 2/ab", state8, b8); else n_pass++;
    sw = {2'b00, 16'h0007};
    key_n[1:0] = 2'b00;
    step(DB + 6);
    key_n[1:0] = 2'b11;
    step(DB + 6);
    n_chk++; if (state8 !== 3'd0) $display("FAIL clr_state got %0d want 0", state8); else n_pass++;
    n_chk++; if ({a8, b8, op8, flags8} !== '0) $display("FAIL clr_regs got %h %h %h %b want 0", a8, b8, op8, flags8); else n_pass++;
    n_chk++; if (hex8 !== exp_hex8(32'h7)) $display("FAIL clr_hex8 got %h want %h", hex8, exp_hex8(32'h7)); else n_pass++;
  endtask

  task automatic test_paging();
    logic [31:0] r; logic [2:0] f;
    sw = {2'b00, 16'h1234}; press(0);
    sw = {2'b00, 16'h5678}; press(0);
    sw = {2'b00, 16'h000A};
    exp_res_q.push_back(32'h1234_5678); exp_flg_q.push_back(3'b000);
    press(0);
    wait_show();
    n_chk++; if (state8 !== 3'd4 || exp_res_q.size() == 0) $display("FAIL page_show st=%0d q=%0d want 4/nonempty", state8, exp_res_q.size()); else n_pass++;
    r = exp_res_q.pop_front(); f = exp_flg_q.pop_front();
    n_chk++; if (hex8 !== exp_hex8(r) || flags8 !== f) $display("FAIL page_hex8 got %h/%b want %h/%b", hex8, flags8, exp_hex8(r), f); else n_pass++;
    n_chk++; if (hex3 !== exp_hex3(r, 0)) $display("FAIL page0 got %h want %h", hex3, exp_hex3(r, 0)); else n_pass++;
    for (int p = 1; p <= 3; p++) begin
      press(2);
      n_chk++; if (hex3 !== exp_hex3(r, p % 3)) $display("FAIL page%0d got %h want %h", p, hex3, exp_hex3(r, p % 3)); else n_pass++;
      n_chk++; if (hex8 !== exp_hex8(r)) $display("FAIL single_page%0d got %h want %h", p, hex8, exp_hex8(r)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [2:0] f;
    int t;
    press(0);
    sw = {2'b00, 16'h0009}; press(0);
    sw = {2'b00, 16'h0003}; press(0);
    sw = {2'b00, 16'h0002};
    key_n[0] = 1'b0;
    t = 0;
    while (state8 !== 3'd3 && t < 30) begin step(1); t++; end
    n_chk++; if (state8 !== 3'd3) $display("FAIL rst_reach_exec st=%0d want 3", state8); else n_pass++;
    nrst = 1'b0;
    #1;
    n_chk++; if (state8 !== 3'd0 || flags8 !== 3'd0 || a8 !== '0) $display("FAIL rst_mid st=%0d fl=%b a=%h want 0/0/0", state8, flags8, a8); else n_pass++;
    n_chk++; if (hex8 !== {8{7'h7F}} || hex3 !== {3{7'h7F}}) $display("FAIL rst_mid_hex got %h %h want blank", hex8, hex3); else n_pass++;
    key_n = 4'hF;
    step(2);
    nrst = 1'b1;
    step(2);
    sw = {2'b00, 16'h0002}; press(0);
    sw = {2'b00, 16'h0002}; press(0);
    sw = {2'b00, 16'h0002};
    exp_res_q.push_back(32'd4); exp_flg_q.push_back(3'b000);
    press(0);
    wait_show();
    n_chk++; if (state8 !== 3'd4 || exp_res_q.size() == 0) $display("FAIL resume_show st=%0d q=%0d want 4/nonempty", state8, exp_res_q.size()); else n_pass++;
    r = exp_res_q.pop_front(); f = exp_flg_q.pop_front();
    n_chk++; if (hex8 !== exp_hex8(r) || flags8 !== f) $display("FAIL resume_hex8 got %h/%b want %h/%b", hex8, flags8, exp_hex8(r), f); else n_pass++;
    n_chk++; if (exp_res_q.size() != 0) $display("FAIL scoreboard_left got %0d want 0", exp_res_q.size()); else n_pass++;
  endtask

  initial begin
    nrst  = 1'b0;
    key_n = 4'hF;
    sw    = '0;
    test_reset();
    test_add();
    test_sign_fill();
    test_debounce();
    test_clear();
    test_paging();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
